// File: rtl/width_conv_pkg.sv
// Shared widths, byte/word types and default FIFO depth for the 8/16-bit
// width converters.
package width_conv_pkg;
  localparam int BYTE_W        = 8;
  localparam int WORD_W        = 16;
  localparam int DEFAULT_DEPTH = 2;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/width_16to8_word_fifo.sv
// word_fifo: DEPTH x WORD_W FIFO, registered write, combinational head read.
// DEPTH must be a power of two so the pointers wrap naturally.
module word_fifo
  import width_conv_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  word_t                    wdata,
  output word_t                    head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  word_t            mem_q [DEPTH];
  word_t            mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking <= only; the comb block above uses =.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is deliberately reset so the head byte reads zero after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/width_16to8.sv
// Unpacks 16-bit words into an 8-bit byte stream through a small word FIFO.
// Define WIDTH_16TO8_LSB_FIRST_EN to emit the low byte first (default MSB-first).
module width_16to8
  import width_conv_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [WORD_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [BYTE_W-1:0] data_out,
  output logic              busy
);
  word_t                 fifo_head;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  sel_q, sel_d;

  assign ready_in  = !fifo_full;
  assign valid_out = !fifo_empty;
  assign busy      = (fifo_count != '0);
  assign fifo_push = valid_in && ready_in;

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (data_in),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The head word is popped only once its second byte has been taken.
  always_comb begin
    sel_d    = sel_q;
    fifo_pop = 1'b0;
    if (valid_out && ready_out) begin
      if (sel_q) begin
        sel_d    = 1'b0;
        fifo_pop = 1'b1;
      end else begin
        sel_d = 1'b1;
      end
    end
  end

  always_comb begin
`ifdef WIDTH_16TO8_LSB_FIRST_EN
    data_out = sel_q ? fifo_head[WORD_W-1:BYTE_W] : fifo_head[BYTE_W-1:0];
`else
    data_out = sel_q ? fifo_head[BYTE_W-1:0] : fifo_head[WORD_W-1:BYTE_W];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= 1'b0;
    else     sel_q <= sel_d;
  end
endmodule

// File: tb/tb_width_16to8.sv
// Scoreboard bench for width_16to8: expected bytes are queued on each accepted
// word and compared as the byte side hands them over.
module tb_width_16to8;
  import width_conv_pkg::*;

  localparam int DEPTH = 2;

  logic  clk = 1'b0;
  logic  rst, valid_in, ready_in, valid_out, ready_out, busy;
  word_t data_in;
  byte_t data_out;

  int    n_checks = 0;
  int    n_fail   = 0;
  byte_t sb [$];

  always #5 clk = ~clk;

  width_16to8 #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .busy      (busy)
  );

  function automatic byte_t first_byte(input word_t w);
`ifdef WIDTH_16TO8_LSB_FIRST_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  function automatic byte_t second_byte(input word_t w);
`ifdef WIDTH_16TO8_LSB_FIRST_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  task automatic expect_word(input word_t w);
    sb.push_back(first_byte(w));
    sb.push_back(second_byte(w));
  endtask

  // One clock: sample registered outputs at the falling edge, then drive inputs.
  task automatic cyc(input logic v, input word_t d, input logic r,
                     output logic ri, output logic vo, output byte_t b);
    @(negedge clk);
    ri = ready_in;
    vo = valid_out;
    b  = data_out;
    valid_in  = v;
    data_in   = d;
    ready_out = r;
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in: got %b, required 1", ready_in); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b, required 0", valid_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h, required 00", data_out); end
  endtask

  task automatic test_single;
    logic ri, vo; byte_t b, exp;
    cyc(1'b1, 16'hA0A1, 1'b1, ri, vo, b);
    n_checks++; if (ri !== 1'b1) begin n_fail++; $display("FAIL single_accept: ready_in %b, required 1", ri); end
    if (ri) expect_word(16'hA0A1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, '0, 1'b1, ri, vo, b);
      exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      n_checks++;
      if (vo !== 1'b1 || b !== exp) begin
        n_fail++; $display("FAIL single_byte%0d: got valid=%b data=%h, required valid=1 data=%h", i, vo, b, exp);
      end
    end
    cyc(1'b0, '0, 1'b1, ri, vo, b);
    n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL single_idle: valid_out %b, required 0", vo); end
  endtask

  task automatic test_stall_mid_word;
    logic ri, vo; byte_t b, exp;
    cyc(1'b1, 16'hA0A1, 1'b0, ri, vo, b);
    if (ri) expect_word(16'hA0A1);
    cyc(1'b0, '0, 1'b1, ri, vo, b);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_checks++; if (vo !== 1'b1 || b !== exp) begin n_fail++; $display("FAIL stall_first: got valid=%b data=%h, required valid=1 data=%h", vo, b, exp); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b0, ri, vo, b);
      exp = (sb.size() != 0) ? sb[0] : 8'hxx;
      n_checks++;
      if (vo !== 1'b1 || b !== exp) begin
        n_fail++; $display("FAIL stall_hold%0d: got valid=%b data=%h, required valid=1 data=%h", i, vo, b, exp);
      end
    end
    cyc(1'b0, '0, 1'b1, ri, vo, b);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_checks++; if (vo !== 1'b1 || b !== exp) begin n_fail++; $display("FAIL stall_second: got valid=%b data=%h, required valid=1 data=%h", vo, b, exp); end
    cyc(1'b0, '0, 1'b1, ri, vo, b);
    n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL stall_idle: valid_out %b, required 0", vo); end
  endtask

  task automatic test_backpressure;
    logic ri, vo, d_taken; byte_t b, exp; int npop;
    cyc(1'b1, 16'hB0B1, 1'b0, ri, vo, b);
    n_checks++; if (ri !== 1'b1) begin n_fail++; $display("FAIL bp_accept1: ready_in %b, required 1", ri); end
    if (ri) expect_word(16'hB0B1);
    cyc(1'b1, 16'hC0C1, 1'b0, ri, vo, b);
    n_checks++; if (ri !== 1'b1) begin n_fail++; $display("FAIL bp_accept2: ready_in %b, required 1", ri); end
    if (ri) expect_word(16'hC0C1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 16'hD0D1, 1'b0, ri, vo, b);
      n_checks++; if (ri !== 1'b0) begin n_fail++; $display("FAIL bp_full%0d: ready_in %b, required 0", i, ri); end
      exp = (sb.size() != 0) ? sb[0] : 8'hxx;
      n_checks++; if (vo !== 1'b1 || b !== exp) begin n_fail++; $display("FAIL bp_hold%0d: got valid=%b data=%h, required valid=1 data=%h", i, vo, b, exp); end
    end
    d_taken = 1'b0; npop = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(!d_taken, 16'hD0D1, 1'b1, ri, vo, b);
      if (!d_taken && ri) begin d_taken = 1'b1; expect_word(16'hD0D1); end
      if (vo) begin
        npop++; n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL bp_byte: got %h, required none", b); end
        else begin exp = sb.pop_front(); if (b !== exp) begin n_fail++; $display("FAIL bp_byte: got %h, required %h", b, exp); end end
      end
    end
    n_checks++;
    if (!d_taken || npop != 6 || sb.size() != 0 || vo !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: taken=%b bytes=%0d left=%0d valid=%b, required taken=1 bytes=6 left=0 valid=0", d_taken, npop, sb.size(), vo);
    end
  endtask

  task automatic test_reset_mid_word;
    logic ri, vo, seen; byte_t b, exp;
    cyc(1'b1, 16'h5566, 1'b0, ri, vo, b);
    if (ri) expect_word(16'h5566);
    cyc(1'b1, 16'h7788, 1'b0, ri, vo, b);
    if (ri) expect_word(16'h7788);
    cyc(1'b0, '0, 1'b1, ri, vo, b);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_checks++; if (vo !== 1'b1 || b !== exp) begin n_fail++; $display("FAIL rst_mid_first: got valid=%b data=%h, required valid=1 data=%h", vo, b, exp); end
    @(negedge clk);
    ready_out = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, required 0", valid_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1, ri, vo, b);
      if (vo) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet: byte seen %b, required 0", seen); end
    cyc(1'b1, 16'h1234, 1'b1, ri, vo, b);
    if (ri) expect_word(16'h1234);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, '0, 1'b1, ri, vo, b);
      exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      n_checks++;
      if (vo !== 1'b1 || b !== exp) begin
        n_fail++; $display("FAIL rst_mid_new%0d: got valid=%b data=%h, required valid=1 data=%h", i, vo, b, exp);
      end
    end
    cyc(1'b0, '0, 1'b1, ri, vo, b);
  endtask

  task automatic test_back_to_back;
    logic ri, vo, ri_ok; byte_t b, exp; word_t w; int npush, npop;
    npush = 0; npop = 0; ri_ok = 1'b1;
    for (int k = 0; k < 18; k++) begin
      w = word_t'($urandom);
      cyc((k < 16) && (k % 2 == 0), w, 1'b1, ri, vo, b);
      if (ri !== 1'b1) ri_ok = 1'b0;
      if ((k < 16) && (k % 2 == 0) && ri) begin npush++; expect_word(w); end
      if (vo) begin
        npop++; n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_byte: got %h, required none", b); end
        else begin exp = sb.pop_front(); if (b !== exp) begin n_fail++; $display("FAIL b2b_byte: got %h, required %h", b, exp); end end
      end
    end
    n_checks++; if (ri_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in: deasserted during stream, required always 1"); end
    n_checks++;
    if (npush != 8 || npop != 16 || sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: words=%0d bytes=%0d left=%0d, required words=8 bytes=16 left=0", npush, npop, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_mid_word();
    test_backpressure();
    test_reset_mid_word();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/width_16to8.md
# width_16to8

Downstream unpacking stage for the 8-to-16 packer: accepts 16-bit words under a valid/ready handshake and emits them as a stream of 8-bit bytes with output backpressure. A small word FIFO decouples the two sides so that upstream bursts are absorbed while the byte side is stalled. Byte order is MSB-first by default, restoring the order the packer received the bytes in.

## Interface
- DEPTH, 2, word FIFO entries; power of two, ≥ 2
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- valid_in  input  1  data_in holds a word
- ready_in  output  1  block can accept a word this cycle
- data_in  input  16  word; [15:8] is the high byte
- valid_out  output  1  data_out holds a byte
- ready_out  input  1  consumer takes the byte this cycle
- data_out  output  8  current byte
- busy  output  1  FIFO non-empty or a word is partially sent

## Operation
- Push: `valid_in && ready_in` at a rising edge writes data_in to the FIFO tail.
- ready_in = (count != DEPTH).
  - Depends only on registered state, never on valid_in or ready_out.
- Byte pointer sel (1 bit) selects the byte of the head word.
  - sel=0 gives the first byte; sel=1 gives the second.
- valid_out = (count != 0).
- data_out = selected byte of the head word, read from FIFO storage with no extra register.
- Pop rules:
  - `valid_out && ready_out` with sel=0 sets sel=1; the FIFO is unchanged.
  - The same condition with sel=1 clears sel and pops the head.
- Push and pop in the same cycle: both take effect and count is unchanged.
  - When full, ready_in is already low, so no push occurs even if a pop happens that cycle.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.
- busy = (count != 0).
- Valid-held rule: when valid_out is high and ready_out is low, data_out and valid_out hold stable.
- Word-held rule: upstream must hold valid_in/data_in until accepted, and may not retract it.

## Timing
- Reset (async assert, sync-safe release) forces:
  - count=0, sel=0, pointers=0
  - ready_in=1, valid_out=0, busy=0
  - data_out=8'h00, because storage is cleared to zero.
- Latency: a word accepted at edge N produces its first byte with valid_out high in the cycle after edge N. The second byte follows at edge N+1 if ready_out=1.
- Throughput with ready_out held high: 1 word per 2 cycles. Upstream at full packer rate never fills the FIFO.
- Reset mid-word discards the half-sent word and all queued words. No byte is emitted after reset until a new push.
- Empty: ready_out is ignored and sel never advances.
- Full: ready_in=0 until the edge at which a head pop occurs; it rises in the following cycle.

## Configuration
- WIDTH_16TO8_LSB_FIRST_EN
  - Undefined: sel=0 outputs data_in[15:8], then [7:0] (MSB-first).
  - Defined: sel=0 outputs [7:0], then [15:8].
- Handshake, latency and reset values are identical in both builds.

## Structure
- Shared package width_conv_pkg:
  - BYTE_W=8, WORD_W=16
  - the byte_t and word_t typedefs
  - default FIFO depth constant
- One sub-module, word_fifo: parameterized DEPTH×WORD_W synchronous-write, combinational-read FIFO.
  - Exposes push, pop, head, full, empty, count.
- Top level holds sel, byte muxing and the handshake logic.

## Test plan
- Reset held 2 cycles, then released. Required: ready_in=1, valid_out=0, busy=0, data_out=8'h00.
- Push 16'hA0A1 with ready_out=1. Required: data_out=A0 in the first cycle after acceptance, then A1, then valid_out=0.
  - With WIDTH_16TO8_LSB_FIRST_EN: A1 then A0.
- ready_out=0, then push 16'hB0B1, 16'hC0C1 (DEPTH=2). Required:
  - ready_in drops after the second accept.
  - A third word held on valid_in is not taken.
  - Releasing ready_out yields B0,B1,C0,C1,(third word bytes) with no loss or duplication.
- Stall mid-word: after A0 is taken, drop ready_out for 3 cycles. Required: data_out stays A1 with valid_out=1 throughout.
- Assert rst while sel=1 with one word queued. Required: valid_out=0 immediately and busy=0. The next push 16'h1234 emits 12 then 34.
- Back-to-back stream of 8 words at 1 word per 2 cycles, ready_out=1. Required: ready_in never deasserts and the byte stream matches the input order exactly.
